ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Parametrised next-generation PS/2 keyboard receiver: synchronises and glitch-filters psClk/psData, deframes 11-bit frames with parity/stop checking and inactivity timeout.
- Decodes make/break/extended (E0) scan-code sequences with optional typematic-repeat suppression.
- Queues key events in a FIFO behind a valid/ready interface.
- Sits between the PS/2 connector pins and game/audio control logic.

Parameters:
- FILTER_LEN, 8: consecutive equal Clk samples required before filtered psClk changes level (min 2).
- TIMEOUT_CYCLES, 50000: Clk cycles without a filtered psClk falling edge before an in-progress frame is abandoned.
- FIFO_DEPTH, 8: event FIFO entries; power of 2, min 2.
- SUPPRESS_REPEAT, 1: 1 = drop typematic repeat makes; 0 = emit every make.

Ports:
- Clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- psClk  in  1  raw PS/2 clock pin.
- psData  in  1  raw PS/2 data pin.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts head; pop when evt_valid && evt_ready.
- evt_code  out  8  scan code of head event.
- evt_ext  out  1  head event had E0 prefix.
- evt_press  out  1  1 = make, 0 = break.
- frame_err  out  1  one-cycle pulse on parity, start, stop or timeout error.
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

Behaviour:
- Reset (async, any time, including mid-frame): all outputs 0; FIFO empty; frame FSM IDLE; decoder BASE; repeat register cleared; synchroniser and filter state 1.
- Input conditioning:
  - psClk and psData each pass through a 2-FF synchroniser.
  - Filtered psClk takes a new level only after FILTER_LEN consecutive identical synchronised samples.
  - A falling edge = filtered level 1 -> 0; this samples synchronised psData in the same cycle.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: edge with data 0 -> DATA, bit count 0. Edge with data 1 is ignored; stay in IDLE, no error.
  - DATA: shift LSB first; after the 8th bit -> PARITY.
  - PARITY: data bits plus parity bit must have odd parity; record the result -> STOP.
  - STOP: data must be 1 and parity good -> byte_valid pulse in this cycle. Otherwise pulse frame_err. Either way -> IDLE.
  - Timeout: a counter cleared on each edge. In any non-IDLE state, reaching TIMEOUT_CYCLES -> IDLE plus frame_err pulse.
  - Any frame error also forces the decoder to BASE, so a pending prefix is discarded.
- Decoder FSM, states BASE, EXT, BRK, EXT_BRK, acting on byte_valid:
  - BASE: E0 -> EXT; F0 -> BRK.
  - BASE: AA, FA, EE, FE, FC, 00, FF and E1 are dropped; stay in BASE.
  - BASE: any other code -> make event {ext=0}.
  - EXT: F0 -> EXT_BRK; E0 stays in EXT; any other code -> make {ext=1}, -> BASE.
  - BRK: code -> break {ext=0}, -> BASE.
  - EXT_BRK: code -> break {ext=1}, -> BASE.
- Repeat suppression (SUPPRESS_REPEAT=1):
  - The repeat register holds {ext, code} of the last emitted make.
  - A make equal to it is dropped.
  - A break equal to it clears the register and is still emitted.
  - A different make overwrites the register.
  - Breaks are never suppressed.
- Latency:
  - Stop-bit edge at cycle N; decoder registers the event and writes the FIFO at N+1.
  - With the FIFO empty and no stall, evt_valid=1 at N+2.
- FIFO:
  - First-word fall-through; outputs are driven from the head entry and hold while evt_valid && !evt_ready.
  - Full with no pop: push is dropped, overflow pulses at N+1.
  - Full with a simultaneous pop: push is accepted.
  - Empty: evt_code, evt_ext and evt_press read 0.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is $clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package ps2_pkg holds:
  - typedef ps2_evt_t (packed {ext, press, code[7:0]});
  - enums frame_state_t and dec_state_t;
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1;
  - the list of dropped response codes.
- One sub-module, ps2_evt_fifo: parametrised FWFT FIFO of ps2_evt_t, depth FIFO_DEPTH, with full/empty and drop-on-full.

Test Plan:
- Frames 1C, then F0 1C, evt_ready=1 -> events {code=1C, ext=0, press=1}, then {1C, 0, 0}; evt_valid rises exactly 2 Clk after each stop-bit edge.
- Frames E0 74, then E0 F0 74 -> events {74, 1, 1}, then {74, 1, 0}; no event is emitted for any prefix byte.
- 1C sent 3 times, then F0 1C, with SUPPRESS_REPEAT=1 -> exactly two events (make, break). With SUPPRESS_REPEAT=0 -> four events.
- Frame 1C with wrong parity bit -> frame_err pulses once, no event. Next valid frame 32 -> event {32, 0, 1}.
- Start bit then 5 data bits, then psClk held high for TIMEOUT_CYCLES -> frame_err pulses once, FSM back in IDLE. Following frame 1C decodes correctly.
- evt_ready=0, nine distinct makes (15,1D,24,2D,2C,35,3C,43,44) with FIFO_DEPTH=8:
  - first eight are queued; the ninth (44) produces one overflow pulse;
  - then evt_ready=1 drains 15..43 in order.
- Additionally: a 0.5 us glitch on psClk is rejected, and a mid-frame reset leaves the next full frame decoding normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: event record, FSM state
// encodings and the set of keyboard response codes that never become key events.
package ps2_pkg;

    typedef struct packed {
        logic       ext;
        logic       press;
        logic [7:0] code;
    } ps2_evt_t;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} frame_state_t;
    typedef enum logic [1:0] {DecBase, DecExt, DecBrk, DecExtBrk} dec_state_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam int unsigned NumDropped = 8;
    localparam logic [NumDropped-1:0][7:0] PS2_DROPPED = {
        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF, PS2_PAUSE
    };

    function automatic logic is_dropped(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NumDropped; i++) begin
            if (code == PS2_DROPPED[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word fall-through FIFO of key events; a push into a full FIFO is dropped and
// flagged unless a pop happens in the same cycle.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  ps2_evt_t data_i,
    input  logic     pop_i,
    output logic     valid_o,
    output ps2_evt_t data_o,
    output logic     overflow_o
);

    localparam int unsigned AW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = AW + 1;

    ps2_evt_t          mem_q [Depth];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              empty, full, do_push, do_pop;

    always_comb begin
        empty      = (cnt_q == '0);
        full       = (cnt_q == CntW'(Depth));
        do_pop     = pop_i && !empty;
        do_push    = push_i && (!full || do_pop);
        overflow_o = push_i && full && !do_pop;
        valid_o    = !empty;
        data_o     = empty ? '0 : mem_q[rd_q];

        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + CntW'(1);
        if (do_pop && !do_push) cnt_d = cnt_q - CntW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the read side is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the raw pins, deframes 11-bit frames, turns scan-code
// sequences into make/break events and queues them behind a valid/ready interface.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN      = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 50000,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned SUPPRESS_REPEAT = 1
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       psClk,
    input  logic       psData,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_press,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [FW-1:0] FiltMax = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TmoMax  = TW'(TIMEOUT_CYCLES - 1);

    logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;

    frame_state_t  fs_q, fs_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_valid, ferr;

    dec_state_t    dec_q, dec_d;
    logic [8:0]    rep_q, rep_d;
    logic [8:0]    dec_key;
    logic          is_make, is_brk, ext_bit;
    ps2_evt_t      evt_q, evt_d, head;
    logic          push_q, push_d;

    // Input conditioning: 2-FF synchronisers, then a run-length filter on the clock.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        fall   = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FiltMax) begin
                filt_d = clk_s2_q;
                fall   = filt_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    always_comb begin
        fs_d       = fs_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        par_ok_d   = par_ok_q;
        byte_valid = 1'b0;
        ferr       = 1'b0;
        tmo_d      = (fs_q == StIdle || fall) ? '0 : tmo_q + TW'(1);
        if (fall) begin
            unique case (fs_q)
                StIdle: begin
                    if (!data_s2_q) begin
                        fs_d   = StData;
                        bcnt_d = '0;
                    end
                end
                StData: begin
                    shift_d = {data_s2_q, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) fs_d = StParity;
                end
                StParity: begin
                    par_ok_d = ^{shift_q, data_s2_q};
                    fs_d     = StStop;
                end
                StStop: begin
                    if (data_s2_q && par_ok_q) byte_valid = 1'b1;
                    else                       ferr       = 1'b1;
                    fs_d = StIdle;
                end
                default: fs_d = StIdle;
            endcase
        end else if (fs_q != StIdle && tmo_q == TmoMax) begin
            fs_d = StIdle;
            ferr = 1'b1;
        end
    end

    always_comb begin
        dec_d   = dec_q;
        is_make = 1'b0;
        is_brk  = 1'b0;
        ext_bit = 1'b0;
        if (ferr) begin
            dec_d = DecBase;
        end else if (byte_valid) begin
            unique case (dec_q)
                DecBase: begin
                    if (shift_q == PS2_EXT)          dec_d = DecExt;
                    else if (shift_q == PS2_BRK)     dec_d = DecBrk;
                    else if (!is_dropped(shift_q))   is_make = 1'b1;
                end
                DecExt: begin
                    if (shift_q == PS2_BRK) begin
                        dec_d = DecExtBrk;
                    end else if (shift_q != PS2_EXT) begin
                        is_make = 1'b1;
                        ext_bit = 1'b1;
                        dec_d   = DecBase;
                    end
                end
                DecBrk: begin
                    is_brk = 1'b1;
                    dec_d  = DecBase;
                end
                DecExtBrk: begin
                    is_brk  = 1'b1;
                    ext_bit = 1'b1;
                    dec_d   = DecBase;
                end
                default: dec_d = DecBase;
            endcase
        end
    end

    // Repeat register: all-zero means empty; 00 is never a make code so it cannot collide.
    always_comb begin
        dec_key = {ext_bit, shift_q};
        rep_d   = rep_q;
        push_d  = 1'b0;
        evt_d   = '0;
        if (is_make && !(SUPPRESS_REPEAT != 0 && dec_key == rep_q)) begin
            push_d = 1'b1;
            evt_d  = '{ext: ext_bit, press: 1'b1, code: shift_q};
            if (SUPPRESS_REPEAT != 0) rep_d = dec_key;
        end
        if (is_brk) begin
            push_d = 1'b1;
            evt_d  = '{ext: ext_bit, press: 1'b0, code: shift_q};
            if (dec_key == rep_q) rep_d = '0;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
            filt_q    <= 1'b1;
            fcnt_q    <= '0;
            fs_q      <= StIdle;
            bcnt_q    <= '0;
            shift_q   <= '0;
            par_ok_q  <= 1'b0;
            tmo_q     <= '0;
            dec_q     <= DecBase;
            rep_q     <= '0;
            evt_q     <= '0;
            push_q    <= 1'b0;
        end else begin
            clk_s1_q  <= psClk;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= psData;
            data_s2_q <= data_s1_q;
            filt_q    <= filt_d;
            fcnt_q    <= fcnt_d;
            fs_q      <= fs_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            par_ok_q  <= par_ok_d;
            tmo_q     <= tmo_d;
            dec_q     <= dec_d;
            rep_q     <= rep_d;
            evt_q     <= evt_d;
            push_q    <= push_d;
        end
    end

    ps2_evt_fifo #(
        .Depth(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (Clk),
        .rst_i      (reset),
        .push_i     (push_q),
        .data_i     (evt_q),
        .pop_i      (evt_ready),
        .valid_o    (evt_valid),
        .data_o     (head),
        .overflow_o (overflow)
    );

    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_press = head.press;
    assign frame_err = ferr;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed PS/2 frames, expected events queued at
// stimulus time and checked by an independent monitor.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

    localparam int unsigned FiltLen = 8;
    localparam int unsigned Tmo     = 2000;
    localparam int unsigned Depth   = 8;
    localparam int          H       = 20;

    logic       Clk = 1'b0, reset = 1'b1, psClk = 1'b1, psData = 1'b1, evt_ready = 1'b1;
    logic       evt_valid, evt_ext, evt_press, frame_err, overflow;
    logic [7:0] evt_code;
    logic       d2_valid, d2_ext, d2_press, d2_ferr, d2_ovf;
    logic [7:0] d2_code;

    logic [9:0] exp_q[$];
    logic [9:0] mon_e;
    int tests = 0, fails = 0, err_cnt = 0, ovf_cnt = 0, d2_cnt = 0;
    int base_err, base_ovf, base_d2;

    always #50 Clk = ~Clk;

    ps2_key_decoder #(
        .FILTER_LEN(FiltLen), .TIMEOUT_CYCLES(Tmo), .FIFO_DEPTH(Depth), .SUPPRESS_REPEAT(1)
    ) u_dut (
        .Clk(Clk), .reset(reset), .psClk(psClk), .psData(psData),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_ext(evt_ext), .evt_press(evt_press), .frame_err(frame_err), .overflow(overflow)
    );

    ps2_key_decoder #(
        .FILTER_LEN(FiltLen), .TIMEOUT_CYCLES(Tmo), .FIFO_DEPTH(Depth), .SUPPRESS_REPEAT(0)
    ) u_dut_norep (
        .Clk(Clk), .reset(reset), .psClk(psClk), .psData(psData),
        .evt_valid(d2_valid), .evt_ready(1'b1), .evt_code(d2_code),
        .evt_ext(d2_ext), .evt_press(d2_press), .frame_err(d2_ferr), .overflow(d2_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_evt(input logic ext, input logic press, input logic [7:0] code);
        exp_q.push_back({ext, press, code});
    endtask

    task automatic ps2_bit(input logic b);
        psData = b;
        repeat (H) @(negedge Clk);
        psClk = 1'b0;
        repeat (H) @(negedge Clk);
        psClk = 1'b1;
    endtask

    // chk_lat: measure Clk edges from the stop-bit psClk fall until evt_valid shows.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit chk_lat,
                              input string name);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        if (!chk_lat) begin
            ps2_bit(1'b1);
        end else begin
            int n;
            psData = 1'b1;
            repeat (H) @(negedge Clk);
            psClk = 1'b0;
            n = 0;
            while (n < 40) begin
                @(posedge Clk);
                @(negedge Clk);
                n++;
                if (evt_valid) break;
            end
            check(name, n, FiltLen + 3);
            repeat (H) @(negedge Clk);
            psClk = 1'b1;
        end
        repeat (H) @(negedge Clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, "");
    endtask

    always @(negedge Clk) begin
        #1;
        if (!reset) begin
            if (frame_err) err_cnt++;
            if (overflow)  ovf_cnt++;
            if (d2_valid)  d2_cnt++;
            if (evt_valid && evt_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_evt: got ext=%0d press=%0d code=%02h, required none",
                             evt_ext, evt_press, evt_code);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({evt_ext, evt_press, evt_code} !== mon_e) begin
                        fails++;
                        $display("FAIL evt: got ext=%0d press=%0d code=%02h, required ext=%0d press=%0d code=%02h",
                                 evt_ext, evt_press, evt_code, mon_e[9], mon_e[8], mon_e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] codes [9];
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

        repeat (3) @(negedge Clk);
        check("rst_valid", evt_valid, 0);
        check("rst_head", {evt_ext, evt_press, evt_code}, 0);
        check("rst_pulses", {frame_err, overflow}, 0);
        reset = 1'b0;
        repeat (5) @(negedge Clk);

        // Make then break with latency measurement
        expect_evt(1'b0, 1'b1, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, "lat_make");
        send(8'hF0);
        expect_evt(1'b0, 1'b0, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, "lat_break");
        check("q_empty_basic", exp_q.size(), 0);

        // Extended make/break; prefixes produce nothing
        expect_evt(1'b1, 1'b1, 8'h74);
        send(8'hE0); send(8'h74);
        expect_evt(1'b1, 1'b0, 8'h74);
        send(8'hE0); send(8'hF0); send(8'h74);
        check("q_empty_ext", exp_q.size(), 0);

        // Typematic repeat: suppressed here, all four seen by the non-suppressing instance
        base_d2 = d2_cnt;
        expect_evt(1'b0, 1'b1, 8'h1C);
        send(8'h1C); send(8'h1C); send(8'h1C);
        expect_evt(1'b0, 1'b0, 8'h1C);
        send(8'hF0); send(8'h1C);
        check("q_empty_repeat", exp_q.size(), 0);
        check("norep_count", d2_cnt - base_d2, 4);

        // Bad parity, then a good frame
        base_err = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0, "");
        check("parity_err", err_cnt - base_err, 1);
        expect_evt(1'b0, 1'b1, 8'h32);
        send(8'h32);
        check("q_empty_parity", exp_q.size(), 0);
        check("parity_no_extra_err", err_cnt - base_err, 1);

        // Truncated frame, then inactivity timeout
        base_err = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(i[0]);
        repeat (Tmo / 2) @(negedge Clk);
        check("tmo_not_early", err_cnt - base_err, 0);
        repeat (Tmo) @(negedge Clk);
        check("tmo_err", err_cnt - base_err, 1);
        expect_evt(1'b0, 1'b1, 8'h1C);
        send(8'h1C);
        check("q_empty_tmo", exp_q.size(), 0);

        // 0.5 us low glitch on psClk with data low must not start a frame
        base_err = err_cnt;
        psData = 1'b0;
        @(negedge Clk);
        psClk = 1'b0;
        repeat (5) @(negedge Clk);
        psClk = 1'b1;
        psData = 1'b1;
        repeat (H) @(negedge Clk);
        expect_evt(1'b0, 1'b1, 8'h5A);
        send(8'h5A);
        check("glitch_no_err", err_cnt - base_err, 0);
        check("q_empty_glitch", exp_q.size(), 0);

        // Reset mid-frame; repeat register cleared so 1C is a fresh make
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        reset = 1'b1;
        repeat (3) @(negedge Clk);
        check("midrst_valid", evt_valid, 0);
        reset = 1'b0;
        repeat (5) @(negedge Clk);
        expect_evt(1'b0, 1'b1, 8'h1C);
        send(8'h1C);
        check("q_empty_midrst", exp_q.size(), 0);

        // Fill the FIFO with the consumer stalled; the ninth event overflows
        evt_ready = 1'b0;
        base_ovf = ovf_cnt;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) expect_evt(1'b0, 1'b1, codes[i]);
            send(codes[i]);
        end
        check("ovf_pulse", ovf_cnt - base_ovf, 1);
        check("full_valid", evt_valid, 1);
        check("full_head_hold", evt_code, 8'h15);
        evt_ready = 1'b1;
        repeat (20) @(negedge Clk);
        check("q_empty_drain", exp_q.size(), 0);
        check("drained_valid", evt_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
